// File: rtl/fp_hazard_unit.sv
// FP interlock/forwarding controller: NSTAGE-deep destination tracking plus div/sqrt occupancy; stall and forward selects are combinational, state updates next edge.
// Defining FP_STALL_CNT_EN builds a saturating stall-cycle counter; otherwise stall_cnt is tied to 0.
module fp_hazard_unit #(
  parameter int NSTAGE = 3,
  parameter int RW     = 5,
  parameter int DIVLAT = 12
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 id_valid,
  input  logic [RW-1:0]        id_fs,
  input  logic [RW-1:0]        id_ft,
  input  logic                 id_ua,
  input  logic                 id_ub,
  input  logic                 id_fwr,
  input  logic [RW-1:0]        id_fd,
  input  logic                 id_div,
  input  logic                 exe_lwc1,
  input  logic [RW-1:0]        exe_ldn,
  input  logic                 mem_lwc1,
  input  logic [RW-1:0]        mem_ldn,
  output logic                 stall,
  output logic                 fwd_la,
  output logic                 fwd_lb,
  output logic                 fwd_fa,
  output logic                 fwd_fb,
  output logic [NSTAGE*RW-1:0] e_n,
  output logic [NSTAGE-1:0]    e_w,
  output logic [7:0]           div_cnt,
  output logic [15:0]          stall_cnt
);

  logic [NSTAGE*RW-1:0] stage_n;
  logic [NSTAGE-1:0]    stage_w;
  logic [7:0]           div_q;
  logic                 busy;
  logic                 use_a, use_b;
  logic                 raw_a, raw_b;
  logic                 fwd_fa_c, fwd_fb_c;
  logic                 fwd_la_c, fwd_lb_c;
  logic                 issue;

  // Stages 1..NSTAGE-1 hold results that are not yet forwardable.
  function automatic logic hit_inflight(input logic [RW-1:0]        src,
                                        input logic [NSTAGE*RW-1:0] n,
                                        input logic [NSTAGE-1:0]    w);
    logic h;
    h = 1'b0;
    for (int k = 1; k < NSTAGE; k++) begin
      if (w[k-1] && (n[k*RW-1 -: RW] == src)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic hit_last(input logic [RW-1:0]        src,
                                    input logic [NSTAGE*RW-1:0] n,
                                    input logic [NSTAGE-1:0]    w);
    return w[NSTAGE-1] && (n[NSTAGE*RW-1 -: RW] == src);
  endfunction

  always_comb begin
    busy     = (div_q != 8'd0);
    use_a    = id_valid && id_ua;
    use_b    = id_valid && id_ub;
    raw_a    = use_a && (hit_inflight(id_fs, stage_n, stage_w) ||
                         (exe_lwc1 && (exe_ldn == id_fs)));
    raw_b    = use_b && (hit_inflight(id_ft, stage_n, stage_w) ||
                         (exe_lwc1 && (exe_ldn == id_ft)));
    fwd_fa_c = use_a && hit_last(id_fs, stage_n, stage_w) && !raw_a;
    fwd_fb_c = use_b && hit_last(id_ft, stage_n, stage_w) && !raw_b;
    fwd_la_c = use_a && mem_lwc1 && (mem_ldn == id_fs) && !fwd_fa_c;
    fwd_lb_c = use_b && mem_lwc1 && (mem_ldn == id_ft) && !fwd_fb_c;
  end

  assign stall  = !clr && (raw_a || raw_b || busy);
  assign fwd_fa = !clr && fwd_fa_c;
  assign fwd_fb = !clr && fwd_fb_c;
  assign fwd_la = !clr && fwd_la_c;
  assign fwd_lb = !clr && fwd_lb_c;
  assign issue  = id_valid && !stall;

  // The whole pipe freezes while div/sqrt is busy; a stalled ID cycle shifts in a bubble.
  always_ff @(posedge clk) begin
    if (clr) begin
      stage_n <= '0;
      stage_w <= '0;
      div_q   <= 8'd0;
    end else if (busy) begin
      div_q <= div_q - 8'd1;
    end else begin
      stage_w <= {stage_w[NSTAGE-2:0], issue && id_fwr};
      stage_n <= {stage_n[(NSTAGE-1)*RW-1:0], id_fd};
      if (issue && id_div) div_q <= 8'(DIVLAT - 1);
    end
  end

  assign e_n     = stage_n;
  assign e_w     = stage_w;
  assign div_cnt = div_q;

`ifdef FP_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_q <= 16'd0;
    end else if (stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
